// File: rtl/alu_ctl_md.sv
// EX-stage ALU control decode with an iterative multiply/divide
// sequencer that owns its HI/LO registers and stalls the pipeline.
module alu_ctl_md #(
    parameter int unsigned WIDTH = 32,
    parameter bit          MD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       ALUctl,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic             div0
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [5:0] F_ADDI  = 6'b001000;
    localparam logic [5:0] F_ANDI  = 6'b001100;
    localparam logic [5:0] F_ORI   = 6'b001101;
    localparam logic [5:0] F_SLTI  = 6'b001010;
    localparam logic [5:0] F_SLTIU = 6'b001011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              sa_q, sa_d;
    logic              bz_q, bz_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  wrk_q, wrk_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;

    logic md_fn, mf_fn, start;
    assign md_fn = (funct[5:2] == 4'b0110);
    assign mf_fn = (funct == F_MFHI) || (funct == F_MFLO);
    assign start = MD_EN && valid && (ALUOp == 2'b10)
                   && md_fn && (state_q == S_IDLE);

    always_comb begin
        ALUctl = 4'b0010;
        unique case (ALUOp)
            2'b11: ALUctl = 4'b0010;
            2'b01: ALUctl = 4'b0110;
            2'b00: begin
                case (funct)
                    F_ADDI:  ALUctl = 4'b0010;
                    F_ANDI:  ALUctl = 4'b0000;
                    F_ORI:   ALUctl = 4'b0001;
                    F_SLTI:  ALUctl = 4'b0111;
                    F_SLTIU: ALUctl = 4'b1000;
                    default: ALUctl = 4'b0010;
                endcase
            end
            2'b10: begin
                case (funct)
                    F_ADD, F_ADDU: ALUctl = 4'b0010;
                    F_SUB, F_SUBU: ALUctl = 4'b0110;
                    F_AND:   ALUctl = 4'b0000;
                    F_OR:    ALUctl = 4'b0001;
                    F_XOR:   ALUctl = 4'b0011;
                    F_NOR:   ALUctl = 4'b1100;
                    F_SLT:   ALUctl = 4'b0111;
                    F_SLTU:  ALUctl = 4'b1000;
                    default: ALUctl = 4'b0010;
                endcase
                if (MD_EN && (md_fn || mf_fn))
                    ALUctl = 4'b1111;
            end
        endcase
    end

    // funct[0]=0 selects the signed variants (mult, div)
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign sgn   = ~funct[0];
    assign sa    = sgn & a[WIDTH-1];
    assign sb    = sgn & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    logic [WIDTH:0]   sum, rsh;
    logic [WIDTH-1:0] rdif;
    logic             ge;
    assign sum  = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
    assign rsh  = {acc_q, wrk_q[WIDTH-1]};
    assign ge   = (rsh >= {1'b0, opb_q});
    assign rdif = rsh[WIDTH-1:0] - opb_q;

    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    assign prod   = {acc_q, wrk_q};
    assign prod_s = neg_q ? -prod : prod;
    // a zero divisor keeps the all-ones quotient unsigned
    assign quo_s  = (neg_q && !bz_q) ? -wrk_q : wrk_q;
    assign rem_s  = sa_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        sa_d     = sa_q;
        bz_d     = bz_q;
        acc_d    = acc_q;
        wrk_d    = wrk_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = funct[1];
                    neg_d    = sa ^ sb;
                    sa_d     = sa;
                    bz_d     = (b == '0);
                    acc_d    = '0;
                    wrk_d    = funct[1] ? mag_a : mag_b;
                    opb_d    = funct[1] ? mag_b : mag_a;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    acc_d = ge ? rdif : rsh[WIDTH-1:0];
                    wrk_d = {wrk_q[WIDTH-2:0], ge};
                end else begin
                    acc_d = sum[WIDTH:1];
                    wrk_d = {sum[0], wrk_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST)
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = rem_s;
                    lo_d = quo_s;
                end else begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            bz_q     <= 1'b0;
            acc_q    <= '0;
            wrk_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            sa_q     <= sa_d;
            bz_q     <= bz_d;
            acc_q    <= acc_d;
            wrk_q    <= wrk_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign stall = !reset && (start || (state_q == S_RUN)
                              || (state_q == S_FIX));
    assign div0  = (state_q == S_DONE) && is_div_q && bz_q;

    always_comb begin
        mf_data = '0;
        if (MD_EN && !reset && (ALUOp == 2'b10)) begin
            if (funct == F_MFHI)
                mf_data = hi_q;
            else if (funct == F_MFLO)
                mf_data = lo_q;
        end
    end

endmodule

// File: tb/tb_alu_ctl_md.sv
// Directed bench for alu_ctl_md: decode table, mult/div sequencing,
// reset mid-operation, back-to-back ops and an 8-bit build.
module tb_alu_ctl_md;

    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic [31:0] a, b;
    logic [3:0]  ctl, ctl_n;
    logic        stall, stall_n;
    logic [31:0] mf, mf_n;
    logic        div0, div0_n;

    logic        v8;
    logic [1:0]  op8;
    logic [5:0]  f8;
    logic [7:0]  a8, b8;
    logic [3:0]  ctl8;
    logic        stall8;
    logic [7:0]  mf8;
    logic        div0_8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_ctl_md #(.WIDTH(32), .MD_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp),
        .funct(funct), .a(a), .b(b), .ALUctl(ctl), .stall(stall),
        .mf_data(mf), .div0(div0)
    );

    alu_ctl_md #(.WIDTH(32), .MD_EN(1'b0)) u_nomd (
        .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp),
        .funct(funct), .a(a), .b(b), .ALUctl(ctl_n), .stall(stall_n),
        .mf_data(mf_n), .div0(div0_n)
    );

    alu_ctl_md #(.WIDTH(8), .MD_EN(1'b1)) u_w8 (
        .clk(clk), .reset(reset), .valid(v8), .ALUOp(op8),
        .funct(f8), .a(a8), .b(b8), .ALUctl(ctl8), .stall(stall8),
        .mf_data(mf8), .div0(div0_8)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic dec(input logic [1:0] op, input logic [5:0] f,
                       input logic [3:0] e, input logic [3:0] en);
        valid = 1'b0;
        ALUOp = op;
        funct = f;
        #1;
        check($sformatf("dec %b/%b", op, f), ctl, e);
        check($sformatf("dec_nomd %b/%b", op, f), ctl_n, en);
    endtask

    // Issues an md op and leaves the bench in its DONE cycle.
    task automatic md_op(input string tag, input logic [5:0] f,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic ed0);
        int n;
        valid = 1'b1;
        ALUOp = 2'b10;
        funct = f;
        a = av;
        b = bv;
        #1;
        if (!stall) begin
            @(posedge clk);
            #1;
        end
        check({tag, " start"}, stall, 1'b1);
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk);
            #1;
            a = ~av;
            b = ~bv;
        end
        check({tag, " stall_len"}, n, 34);
        check({tag, " div0"}, div0, ed0);
        funct = MFHI;
        #1;
        check({tag, " hi"}, mf, ehi);
        funct = MFLO;
        #1;
        check({tag, " lo"}, mf, elo);
    endtask

    task automatic idle(input string tag);
        valid = 1'b0;
        funct = 6'b000000;
        @(posedge clk);
        #1;
        check({tag, " div0_off"}, div0, 1'b0);
        check({tag, " idle_stall"}, stall, 1'b0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        valid = 1'b0;
        ALUOp = 2'b00;
        funct = 6'b0;
        a = '0;
        b = '0;
        v8 = 1'b0;
        op8 = 2'b00;
        f8 = 6'b0;
        a8 = '0;
        b8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst stall", stall, 1'b0);
        check("rst div0", div0, 1'b0);
        reset = 1'b0;
        ALUOp = 2'b10;
        funct = MFHI;
        #1;
        check("rst hi", mf, 32'h0);
        funct = MFLO;
        #1;
        check("rst lo", mf, 32'h0);

        dec(2'b11, 6'b000000, 4'b0010, 4'b0010);
        dec(2'b01, 6'b000000, 4'b0110, 4'b0110);
        dec(2'b00, 6'b001000, 4'b0010, 4'b0010);
        dec(2'b00, 6'b001100, 4'b0000, 4'b0000);
        dec(2'b00, 6'b001101, 4'b0001, 4'b0001);
        dec(2'b00, 6'b001010, 4'b0111, 4'b0111);
        dec(2'b00, 6'b001011, 4'b1000, 4'b1000);
        dec(2'b00, 6'b000000, 4'b0010, 4'b0010);
        dec(2'b10, 6'b100000, 4'b0010, 4'b0010);
        dec(2'b10, 6'b100001, 4'b0010, 4'b0010);
        dec(2'b10, 6'b100010, 4'b0110, 4'b0110);
        dec(2'b10, 6'b100011, 4'b0110, 4'b0110);
        dec(2'b10, 6'b100100, 4'b0000, 4'b0000);
        dec(2'b10, 6'b100101, 4'b0001, 4'b0001);
        dec(2'b10, 6'b100110, 4'b0011, 4'b0011);
        dec(2'b10, 6'b100111, 4'b1100, 4'b1100);
        dec(2'b10, 6'b101010, 4'b0111, 4'b0111);
        dec(2'b10, 6'b101011, 4'b1000, 4'b1000);
        dec(2'b10, 6'b111111, 4'b0010, 4'b0010);
        dec(2'b10, MULT,  4'b1111, 4'b0010);
        dec(2'b10, MULTU, 4'b1111, 4'b0010);
        dec(2'b10, DIV,   4'b1111, 4'b0010);
        dec(2'b10, DIVU,  4'b1111, 4'b0010);
        dec(2'b10, MFHI,  4'b1111, 4'b0010);
        dec(2'b10, MFLO,  4'b1111, 4'b0010);

        @(posedge clk);
        #1;
        check("valid0 no start", stall, 1'b0);

        valid = 1'b1;
        ALUOp = 2'b10;
        funct = MULT;
        a = 32'hFFFF_FFFD;
        b = 32'h5;
        #1;
        check("nomd stall", stall_n, 1'b0);
        md_op("mult -3*5", MULT, 32'hFFFF_FFFD, 32'h5,
              32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        idle("mult -3*5");

        md_op("multu", MULTU, 32'hFFFF_FFFF, 32'h2,
              32'h1, 32'hFFFF_FFFE, 1'b0);
        idle("multu");
        md_op("divu 100/7", DIVU, 32'd100, 32'd7,
              32'h2, 32'hE, 1'b0);
        idle("divu 100/7");
        md_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'h2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        idle("div -7/2");
        md_op("div 7/-2", DIV, 32'h7, 32'hFFFF_FFFE,
              32'h1, 32'hFFFF_FFFD, 1'b0);
        idle("div 7/-2");
        md_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000, 1'b0);
        idle("div min/-1");
        md_op("divu 9/0", DIVU, 32'h9, 32'h0,
              32'h9, 32'hFFFF_FFFF, 1'b1);
        idle("divu 9/0");
        md_op("div -9/0", DIV, 32'hFFFF_FFF7, 32'h0,
              32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        idle("div -9/0");

        valid = 1'b1;
        ALUOp = 2'b10;
        funct = MULT;
        a = 32'h0001_0000;
        b = 32'h0001_0000;
        #1;
        repeat (11) @(posedge clk);
        #1;
        check("midrst run", stall, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst stall_in", stall, 1'b0);
        @(posedge clk);
        #1;
        check("midrst stall_after", stall, 1'b0);
        reset = 1'b0;
        funct = MFHI;
        #1;
        check("midrst hi", mf, 32'h0);
        funct = MFLO;
        #1;
        check("midrst lo", mf, 32'h0);
        md_op("restart mult", MULT, 32'h0001_0000, 32'h0001_0000,
              32'h1, 32'h0, 1'b0);
        idle("restart mult");

        md_op("b2b mult", MULT, 32'h7, 32'hFFFF_FFFA,
              32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0);
        md_op("b2b div", DIV, 32'd100, 32'hFFFF_FFF9,
              32'h2, 32'hFFFF_FFF2, 1'b0);
        idle("b2b div");

        v8 = 1'b1;
        op8 = 2'b10;
        f8 = MULTU;
        a8 = 8'hFF;
        b8 = 8'hFF;
        #1;
        n = 0;
        while (stall8 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("w8 stall_len", n, 10);
        f8 = MFHI;
        #1;
        check("w8 hi", mf8, 8'hFE);
        f8 = MFLO;
        #1;
        check("w8 lo", mf8, 8'h01);
        v8 = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
